fwd_scoreboard_unit: RTL and testbench
======================================

Name: fwd_scoreboard_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined RISC-V core.
- Keeps a registered scoreboard of the last DEPTH issued instructions: destination, write-enable, is-load.
- For NSRC source operands it produces bypass selects and a load-use stall.
- Sits beside decode/execute; the datapath muxes consume fwd_sel, and the fetch/decode stall logic consumes stall.

Parameters:
- DEPTH, 3: number of in-flight stages tracked after issue. Slot 0 is the youngest; slot DEPTH-1 is the last before the regfile write is visible.
- NSRC, 2: number of source operands checked per cycle.
- LOAD_LAT, 2: slot index at which load data first becomes forwardable. Legal range 1..DEPTH.
- RA_W, 5: register address width.
- SEL_W, $clog2(DEPTH+1): width of one forward select.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction leaving decode this cycle
- issue_rd  in  RA_W  its destination register
- issue_regwe  in  1  it writes the regfile
- issue_is_load  in  1  it is a load (OPC_LOAD)
- src_addr  in  NSRC*RA_W  source register addresses, operand i at [i*RA_W +: RA_W]
- src_used  in  NSRC  operand i is actually read
- flush_mask  in  DEPTH  invalidate selected slots at the next edge (branch/jump kill)
- fwd_sel  out  NSRC*SEL_W  per operand: 0 = regfile, k+1 = forward from slot k
- stall  out  1  hold decode/fetch; a bubble is inserted
- perf_stall_cnt  out  32  stall-cycle count (see Optional Feature)
- perf_fwd_cnt  out  32  forwarded-operand count (see Optional Feature)

Behaviour:
- Slot state per entry: valid, rd, regwe, is_load. Registered on the clk rising edge.
- Asynchronous clear when rst_n=0: all valid=0, both counters=0. Outputs then read fwd_sel=0 and stall=0 with no clock required.
- Every cycle, slot k+1 takes slot k, and slot DEPTH-1 is discarded. The pipeline never stalls behind the scoreboard.
- Slot 0 load:
  - If issue_valid && !stall: slot 0 takes {1, issue_rd, issue_regwe, issue_is_load}.
  - Otherwise slot 0 takes a bubble (valid=0).
- flush_mask[k]=1 clears the valid bit of the entry that would land in slot k+1 after the shift. flush_mask[DEPTH-1] has no effect.
  - A flush takes priority over the new issue for slot 0 only when bit 0 is set: issued entry is not written, bubble instead.
- Match for operand i: slot k matches when valid && regwe && rd==src_addr[i] && src_addr[i]!=0 && src_used[i].
  - x0 is never forwarded.
- Select: fwd_sel[i] = k+1 for the smallest matching k (youngest wins). 0 if no match.
  - Combinational from state and src inputs; zero-cycle latency.
- Load-use: stall=1 if any operand's winning slot k has is_load=1 and k < LOAD_LAT-1.
  - A stall lasts exactly LOAD_LAT-1-k cycles, because the entry advances one slot per cycle while bubbles enter behind it.
  - fwd_sel stays valid during a stall and points at the advancing slot.
- Simultaneous events:
  - Both operands hazard on different loads: stall until the later-ready one is forwardable.
  - Same rd in two slots: the younger one shadows the older, including when the younger is a non-load; no stall in that case.
- Reset mid-stall: stall drops immediately as rst_n falls, and all entries are lost.

Optional Feature:
- Macro: FWD_SB_PERF_EN.
- Defined:
  - perf_stall_cnt increments every cycle stall=1.
  - perf_fwd_cnt increments by the number of operands with fwd_sel!=0 in that cycle.
  - Both are 32-bit, wrap modulo 2^32, and clear only on reset.
- Undefined: both ports are driven constant 0 and no counter flops are synthesised.

Test Plan:
- Forward from slot 0: DEPTH=3, LOAD_LAT=2. Issue ADD rd=5 in cycle 0; cycle 1 src_addr[0]=5, src_used=1 -> fwd_sel[0]=1, stall=0.
- Load-use stall: issue LW rd=7 in cycle 0; cycle 1 src=7 -> stall=1 for 1 cycle. Cycle 2 -> fwd_sel=2, stall=0, and slot 0 holds a bubble.
- x0 and regwe: issue rd=0 regwe=1, then a store rd=3 regwe=0. Read src 0 and src 3 -> fwd_sel=0 for both.
- Youngest wins: issue ADDI rd=9, then LW rd=9. Next cycle src=9 -> fwd_sel=1, stall=1. Reversed order (LW first, then ADDI) -> fwd_sel=1, stall=0.
- Flush: issue LW rd=4 with flush_mask=3'b001 in the following cycle, then src=4 -> no match, fwd_sel=0, stall=0.
- Reset and counters (FWD_SB_PERF_EN defined):
  - Pull rst_n low during a stall -> stall=0 asynchronously; after release fwd_sel=0 and counters=0.
  - 3 stall cycles and 5 forwarded operands -> perf_stall_cnt=3, perf_fwd_cnt=5.

Source files
------------

// File: rtl/fwd_scoreboard_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fwd_scoreboard_unit - operand bypass select and load-use stall scoreboard.
// Optional perf counters enabled by defining FWD_SB_PERF_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module fwd_scoreboard_unit #(
  parameter int DEPTH    = 3,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 2,
  parameter int RA_W     = 5,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic [RA_W-1:0]        issue_rd,
  input  logic                   issue_regwe,
  input  logic                   issue_is_load,
  input  logic [NSRC*RA_W-1:0]   src_addr,
  input  logic [NSRC-1:0]        src_used,
  input  logic [DEPTH-1:0]       flush_mask,
  output logic [NSRC*SEL_W-1:0]  fwd_sel,
  output logic                   stall,
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_fwd_cnt
);

  logic [DEPTH-1:0]           valid_q, valid_d;
  logic [DEPTH-1:0][RA_W-1:0] rd_q, rd_d;
  logic [DEPTH-1:0]           regwe_q, regwe_d;
  logic [DEPTH-1:0]           load_q, load_d;
  logic [NSRC-1:0]            hazard;

  // The oldest slot is discarded at the next edge, so its flush bit is moot.
  logic unused_flush_top;
  assign unused_flush_top = flush_mask[DEPTH-1];

  // Walk oldest to youngest so the youngest matching slot wins.
  always_comb begin
    fwd_sel = '0;
    hazard  = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (valid_q[k] && regwe_q[k] && src_used[i] &&
            (src_addr[i*RA_W +: RA_W] != '0) &&
            (rd_q[k] == src_addr[i*RA_W +: RA_W])) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          hazard[i]                 = load_q[k] && (k < LOAD_LAT - 1);
        end
      end
    end
  end

  assign stall = |hazard;

  always_comb begin
    valid_d = '0;
    rd_d    = rd_q;
    regwe_d = regwe_q;
    load_d  = load_q;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      valid_d[k] = valid_q[k-1] && !flush_mask[k-1];
      rd_d[k]    = rd_q[k-1];
      regwe_d[k] = regwe_q[k-1];
      load_d[k]  = load_q[k-1];
    end
    // A stalled or killed issue becomes a bubble in slot 0.
    valid_d[0] = issue_valid && !stall && !flush_mask[0];
    rd_d[0]    = issue_rd;
    regwe_d[0] = issue_regwe;
    load_d[0]  = issue_is_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rd_q    <= '0;
      regwe_q <= '0;
      load_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      regwe_q <= regwe_d;
      load_q  <= load_d;
    end
  end

`ifdef FWD_SB_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
    fwd_cnt_d   = fwd_cnt_q;
    for (int i = 0; i < NSRC; i++) begin
      if (fwd_sel[i*SEL_W +: SEL_W] != '0) begin
        fwd_cnt_d = fwd_cnt_d + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_fwd_cnt   = fwd_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_fwd_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard_unit.sv
`default_nettype none
// Bench for fwd_scoreboard_unit: directed vector table, hand sequences and a
// randomized run against a timestamp-based reference model.
module tb_fwd_scoreboard_unit;

  localparam int DEPTH    = 3;
  localparam int NSRC     = 2;
  localparam int LOAD_LAT = 2;
  localparam int RA_W     = 5;
  localparam int SEL_W    = 2;
`ifdef FWD_SB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                  clk;
  logic                  rst_n;
  logic                  issue_valid;
  logic [RA_W-1:0]       issue_rd;
  logic                  issue_regwe;
  logic                  issue_is_load;
  logic [NSRC*RA_W-1:0]  src_addr;
  logic [NSRC-1:0]       src_used;
  logic [DEPTH-1:0]      flush_mask;
  logic [NSRC*SEL_W-1:0] fwd_sel;
  logic                  stall;
  logic [31:0]           perf_stall_cnt;
  logic [31:0]           perf_fwd_cnt;

  fwd_scoreboard_unit #(
    .DEPTH(DEPTH), .NSRC(NSRC), .LOAD_LAT(LOAD_LAT), .RA_W(RA_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regwe(issue_regwe), .issue_is_load(issue_is_load),
    .src_addr(src_addr), .src_used(src_used), .flush_mask(flush_mask),
    .fwd_sel(fwd_sel), .stall(stall),
    .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [4:0] ird;
    logic       iwe;
    logic       ild;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] used;
    logic [2:0] fl;
    logic [1:0] e0;
    logic [1:0] e1;
    logic       est;
  } vec_t;

  // Reference model: each issued instruction is remembered with its issue
  // cycle; its slot at cycle t is t - cyc - 1.
  typedef struct {
    int cyc;
    int rd;
    bit we;
    bit ld;
    bit killed;
  } ent_t;

  ent_t        hist[$];
  int          t_now;
  int unsigned m_stall_cnt;
  int unsigned m_fwd_cnt;
  int          checks;
  int          failures;
  vec_t        tbl[31];

  function automatic vec_t mk(input int iv, input int ird, input int iwe, input int ild,
                              input int s0, input int s1, input int used, input int fl,
                              input int e0, input int e1, input int est);
    vec_t v;
    v.iv = 1'(iv);   v.ird = 5'(ird); v.iwe = 1'(iwe); v.ild = 1'(ild);
    v.s0 = 5'(s0);   v.s1 = 5'(s1);   v.used = 2'(used); v.fl = 3'(fl);
    v.e0 = 2'(e0);   v.e1 = 2'(e1);   v.est = 1'(est);
    return v;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void lookup(input int src, input bit used, output int sel, output bit haz);
    int best;
    sel  = 0;
    haz  = 1'b0;
    best = DEPTH;
    foreach (hist[j]) begin
      int slot;
      slot = t_now - hist[j].cyc - 1;
      if (used && src != 0 && !hist[j].killed && hist[j].we && hist[j].rd == src &&
          slot >= 0 && slot < best) begin
        best = slot;
        sel  = slot + 1;
        haz  = hist[j].ld && (slot < LOAD_LAT - 1);
      end
    end
  endfunction

  function automatic void model_advance(input vec_t v, input bit st);
    foreach (hist[j]) begin
      int slot;
      slot = t_now - hist[j].cyc - 1;
      if (slot >= 0 && slot < DEPTH - 1 && v.fl[slot]) hist[j].killed = 1'b1;
    end
    if (v.iv && !st && !v.fl[0])
      hist.push_back('{cyc: t_now, rd: int'(v.ird), we: v.iwe, ld: v.ild, killed: 1'b0});
    t_now++;
    while (hist.size() > 0 && t_now - hist[0].cyc - 1 >= DEPTH) void'(hist.pop_front());
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_stall_cnt = 0;
    m_fwd_cnt   = 0;
  endfunction

  function automatic void chk_counters(input string tag);
    chk({tag, "_perf_stall"}, 64'(perf_stall_cnt), 64'(PERF ? m_stall_cnt : 32'd0));
    chk({tag, "_perf_fwd"},   64'(perf_fwd_cnt),   64'(PERF ? m_fwd_cnt : 32'd0));
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input vec_t v, input bit use_tbl, input string tag);
    int  m0, m1;
    bit  h0, h1, mst;
    issue_valid   = v.iv;
    issue_rd      = v.ird;
    issue_regwe   = v.iwe;
    issue_is_load = v.ild;
    src_addr      = {v.s1, v.s0};
    src_used      = v.used;
    flush_mask    = v.fl;
    @(negedge clk);
    lookup(int'(v.s0), v.used[0], m0, h0);
    lookup(int'(v.s1), v.used[1], m1, h1);
    mst = h0 | h1;
    chk({tag, "_model_sel0"},  64'(fwd_sel[1:0]), 64'(m0));
    chk({tag, "_model_sel1"},  64'(fwd_sel[3:2]), 64'(m1));
    chk({tag, "_model_stall"}, 64'(stall),        64'(mst));
    chk_counters(tag);
    if (use_tbl) begin
      chk({tag, "_tbl_sel0"},  64'(fwd_sel[1:0]), 64'(v.e0));
      chk({tag, "_tbl_sel1"},  64'(fwd_sel[3:2]), 64'(v.e1));
      chk({tag, "_tbl_stall"}, 64'(stall),        64'(v.est));
    end
    if (mst) m_stall_cnt++;
    m_fwd_cnt += ((m0 != 0) ? 1 : 0) + ((m1 != 0) ? 1 : 0);
    @(posedge clk);
    model_advance(v, mst);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    checks = 0; failures = 0; t_now = 0;
    model_reset();

    // Directed program, DEPTH=3 LOAD_LAT=2.
    tbl[0]  = mk(1, 5,1,0,   0, 0,0,0, 0,0,0);  // ADD x5
    tbl[1]  = mk(0, 0,0,0,   5, 0,1,0, 1,0,0);  // forward slot 0
    tbl[2]  = mk(1, 7,1,1,   0, 0,0,0, 0,0,0);  // LW x7
    tbl[3]  = mk(1, 8,1,0,   7, 0,1,0, 1,0,1);  // load-use stall, x8 dropped
    tbl[4]  = mk(0, 0,0,0,   7, 8,3,0, 2,0,0);  // bubble behind the load
    tbl[5]  = mk(1, 0,1,0,   0, 0,0,0, 0,0,0);  // writes x0
    tbl[6]  = mk(1, 3,0,0,   0, 0,0,0, 0,0,0);  // store, no regwe
    tbl[7]  = mk(0, 0,0,0,   0, 3,3,0, 0,0,0);
    tbl[8]  = mk(1, 9,1,0,   0, 0,0,0, 0,0,0);  // ADDI x9
    tbl[9]  = mk(1, 9,1,1,   0, 0,0,0, 0,0,0);  // LW x9
    tbl[10] = mk(0, 0,0,0,   9, 0,1,0, 1,0,1);
    tbl[11] = mk(0, 0,0,0,   9, 0,1,0, 2,0,0);
    tbl[12] = mk(1,10,1,1,   0, 0,0,0, 0,0,0);  // LW x10
    tbl[13] = mk(1,10,1,0,   0, 0,0,0, 0,0,0);  // ADDI x10 shadows it
    tbl[14] = mk(0, 0,0,0,  10, 0,1,0, 1,0,0);
    tbl[15] = mk(1, 4,1,1,   0, 0,0,0, 0,0,0);  // LW x4
    tbl[16] = mk(1, 4,1,0,   0, 0,0,1, 0,0,0);  // flush bit 0 kills both
    tbl[17] = mk(0, 0,0,0,   4, 0,1,0, 0,0,0);
    tbl[18] = mk(1,11,1,0,   0, 0,0,0, 0,0,0);
    tbl[19] = mk(0, 0,0,0,   0, 0,0,0, 0,0,0);
    tbl[20] = mk(0, 0,0,0,  11, 0,1,2, 2,0,0);  // still visible this cycle
    tbl[21] = mk(0, 0,0,0,  11, 0,1,0, 0,0,0);
    // Counter program: 3 stall cycles, 5 forwarded operands.
    tbl[22] = mk(1,13,1,1,   0, 0,0,0, 0,0,0);
    tbl[23] = mk(0, 0,0,0,  13, 0,1,0, 1,0,1);
    tbl[24] = mk(0, 0,0,0,  13, 0,1,0, 2,0,0);
    tbl[25] = mk(1,14,1,1,   0, 0,0,0, 0,0,0);
    tbl[26] = mk(0, 0,0,0,   0,14,2,0, 0,1,1);
    tbl[27] = mk(0, 0,0,0,   0,14,2,0, 0,2,0);
    tbl[28] = mk(1,15,1,1,   0, 0,0,0, 0,0,0);
    tbl[29] = mk(0, 0,0,0,  15, 0,1,0, 1,0,1);
    tbl[30] = mk(0, 0,0,0,   0, 0,0,0, 0,0,0);

    // Reset state, with inputs that would otherwise look up registers.
    rst_n = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd5; issue_regwe = 1'b1; issue_is_load = 1'b1;
    src_addr = {5'd5, 5'd5}; src_used = 2'b11; flush_mask = '0;
    @(posedge clk); @(negedge clk);
    chk("reset_fwd_sel", 64'(fwd_sel), 64'd0);
    chk("reset_stall",   64'(stall),   64'd0);
    chk_counters("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int r = 0; r < 22; r++) step(tbl[r], 1'b1, $sformatf("tbl%0d", r));
    #3;
    chk("tbl_stall_total", 64'(perf_stall_cnt), PERF ? 64'd2 : 64'd0);
    chk("tbl_fwd_total",   64'(perf_fwd_cnt),   PERF ? 64'd7 : 64'd0);
    @(posedge clk); #1;
    v = mk(0,0,0,0, 0,0,0,0, 0,0,0);
    model_advance(v, 1'b0);

    // Asynchronous reset in the middle of a load-use stall.
    step(mk(1,12,1,1, 0,0,0,0, 0,0,0), 1'b0, "pre_rst");
    issue_valid = 1'b0; src_addr = {5'd0, 5'd12}; src_used = 2'b01; flush_mask = '0;
    @(negedge clk);
    chk("midstall_stall", 64'(stall), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_stall",   64'(stall),   64'd0);
    chk("async_rst_fwd_sel", 64'(fwd_sel), 64'd0);
    model_reset();
    chk_counters("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(mk(0,0,0,0, 12,0,1,0, 0,0,0), 1'b1, "post_rst");

    for (int r = 22; r < 31; r++) step(tbl[r], 1'b1, $sformatf("tbl%0d", r));
    #3;
    chk("cnt_stall_total", 64'(perf_stall_cnt), PERF ? 64'd3 : 64'd0);
    chk("cnt_fwd_total",   64'(perf_fwd_cnt),   PERF ? 64'd5 : 64'd0);
    @(posedge clk); #1;
    model_advance(v, 1'b0);

    // Randomized traffic over a small register set to force overlaps.
    for (int n = 0; n < 800; n++) begin
      int fl;
      fl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 7)) : 0;
      v = mk(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 3)),
             ($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), fl, 0, 0, 0);
      step(v, 1'b0, $sformatf("rnd%0d", n));
    end
    #3;
    chk_counters("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
